// File: rtl/locked_cla_adder_pipe_if.sv
// Operand/result handshake and serial key-load signals of locked_cla_adder_pipe.
// master drives operands, downstream ready and key bits; slave is the adder.
interface locked_cla_adder_pipe_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] add1_i;
  logic [WIDTH-1:0] add2_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH:0]   result_o;
  logic             out_valid_o;
  logic             out_ready_i;
  logic             key_start_i;
  logic             key_bit_i;
  logic             key_shift_i;
  logic             key_loaded_o;

  modport master (
    output add1_i, add2_i, in_valid_i, out_ready_i,
    output key_start_i, key_bit_i, key_shift_i,
    input  in_ready_o, result_o, out_valid_o, key_loaded_o
  );

  modport slave (
    input  add1_i, add2_i, in_valid_i, out_ready_i,
    input  key_start_i, key_bit_i, key_shift_i,
    output in_ready_o, result_o, out_valid_o, key_loaded_o
  );
endinterface

// File: rtl/locked_cla_adder_pipe.sv
// Key-locked carry-lookahead adder, two-stage valid/ready pipeline, serial key load.
// The carry into every group and the LSB sum bit of every group pass through an
// XOR gate driven by (key_act ^ KEY_REF); only the reference key gives a true sum.
//
// Key-load FSM:
//   state | meaning
//   IDLE  | no key loaded since reset, key_act = 0
//   LOAD  | collecting KEY_W serial bits, MSB first
//   ARMED | key_act holds a completely loaded key
module locked_cla_adder_pipe #(
  parameter int                         WIDTH   = 32,
  parameter int                         GROUP   = 4,
  parameter logic [2*(WIDTH/GROUP)-1:0] KEY_REF = 16'hA5C3
) (
  input logic                    clk_i,
  input logic                    rst_i,
  locked_cla_adder_pipe_if.slave bus
);
  localparam int NGRP  = WIDTH / GROUP;
  localparam int KEY_W = 2 * NGRP;
  localparam int CNT_W = $clog2(KEY_W + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ARMED = 2'd2
  } key_state_t;

  // Pipeline state
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [NGRP-1:0]  s1_prop;
  logic [NGRP-1:0]  s1_gen;
  logic             out_valid_q;
  logic [WIDTH:0]   result_q;

  logic [NGRP-1:0]  prop_d;
  logic [NGRP-1:0]  gen_d;
  logic [NGRP-1:0]  carry;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;
  logic             s2_load;
  logic             in_ready;

  // Key state
  key_state_t       key_state_q;
  key_state_t       key_state_d;
  logic [KEY_W-2:0] shift_q;
  logic [KEY_W-1:0] shift_next;
  logic [CNT_W-1:0] bit_cnt_q;
  logic [KEY_W-1:0] key_act_q;
  logic             key_loaded_q;
  logic             cnt_clear;
  logic             shift_en;
  logic             load_done;
  logic [KEY_W-1:0] mis;

  assign mis = key_act_q ^ KEY_REF;

  assign s2_load  = ~out_valid_q | bus.out_ready_i;
  assign in_ready = ~s1_valid | s2_load;

  assign bus.in_ready_o   = in_ready;
  assign bus.out_valid_o  = out_valid_q;
  assign bus.result_o     = result_q;
  assign bus.key_loaded_o = key_loaded_q;

  // Group generate/propagate from the raw operands. A group generates exactly
  // when a > (2^GROUP-1-b), i.e. a > ~b, which avoids a throw-away adder.
  for (genvar g = 0; g < NGRP; g++) begin : g_pg
    assign gen_d[g]  = bus.add1_i[g*GROUP +: GROUP] > ~bus.add2_i[g*GROUP +: GROUP];
    assign prop_d[g] = &(bus.add1_i[g*GROUP +: GROUP] ^ bus.add2_i[g*GROUP +: GROUP]);
  end

  // Lookahead carry chain with key gates; the final group carry-out is ungated.
  assign carry[0] = mis[0];
  for (genvar g = 0; g < NGRP; g++) begin : g_sum
    logic             co;
    logic [GROUP-1:0] s_raw;
    assign co    = s1_gen[g] | (s1_prop[g] & carry[g]);
    assign s_raw = s1_a[g*GROUP +: GROUP] + s1_b[g*GROUP +: GROUP] + GROUP'(carry[g]);
    assign sum_d[g*GROUP +: GROUP] = s_raw ^ GROUP'(mis[NGRP+g]);
    if (g < NGRP - 1) begin : g_mid
      assign carry[g+1] = co ^ mis[g+1];
    end else begin : g_last
      assign cout_d = co;
    end
  end

  // Stage 1: capture an accepted operand pair with its group P/G.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_prop  <= '0;
      s1_gen   <= '0;
    end else if (in_ready) begin
      s1_valid <= bus.in_valid_i;
      if (bus.in_valid_i) begin
        s1_a    <= bus.add1_i;
        s1_b    <= bus.add2_i;
        s1_prop <= prop_d;
        s1_gen  <= gen_d;
      end
    end
  end

  // Stage 2: register the keyed sum whenever the output slot is free; hold while stalled.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
    end else if (s2_load) begin
      out_valid_q <= s1_valid;
      if (s1_valid) begin
        result_q <= {cout_d, sum_d};
      end
    end
  end

  // Key FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      key_state_q <= ST_IDLE;
    end else begin
      key_state_q <= key_state_d;
    end
  end

  // Key FSM next state and load controls; a start in LOAD wins over a shift.
  always_comb begin
    key_state_d = key_state_q;
    cnt_clear   = 1'b0;
    shift_en    = 1'b0;
    load_done   = 1'b0;
    unique case (key_state_q)
      ST_IDLE, ST_ARMED: begin
        if (bus.key_start_i) begin
          key_state_d = ST_LOAD;
          cnt_clear   = 1'b1;
        end
      end
      ST_LOAD: begin
        if (bus.key_start_i) begin
          cnt_clear = 1'b1;
        end else if (bus.key_shift_i) begin
          shift_en = 1'b1;
          if (bit_cnt_q == CNT_W'(KEY_W - 1)) begin
            load_done   = 1'b1;
            key_state_d = ST_ARMED;
          end
        end
      end
      default: key_state_d = ST_IDLE;
    endcase
  end

  // Only KEY_W-1 shift bits are stored: the last bit goes straight into key_act.
  assign shift_next = {shift_q, bus.key_bit_i};

  // Shift register, bit counter and active key.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      key_act_q    <= '0;
      key_loaded_q <= 1'b0;
    end else begin
      if (cnt_clear) begin
        bit_cnt_q <= '0;
      end else if (shift_en) begin
        bit_cnt_q <= bit_cnt_q + 1'b1;
      end
      if (shift_en) begin
        shift_q <= shift_next[KEY_W-2:0];
      end
      if (load_done) begin
        key_act_q    <= shift_next;
        key_loaded_q <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_locked_cla_adder_pipe.sv
// Bench for locked_cla_adder_pipe: directed scenarios plus randomized traffic,
// all compared every cycle against a behavioural model of the keyed adder.
module tb_locked_cla_adder_pipe;
  localparam int          W       = 32;
  localparam logic [15:0] KEY_REF = 16'hA5C3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  locked_cla_adder_pipe_if #(.WIDTH(W)) bus_if ();

  locked_cla_adder_pipe #(.WIDTH(W), .GROUP(4), .KEY_REF(KEY_REF)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_if)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Keyed adder rule, group by group, in plain integer arithmetic.
  function automatic logic [32:0] ref_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic [15:0] key);
    logic [15:0] m;
    logic [32:0] r;
    int c;
    int s;
    m = key ^ KEY_REF;
    r = '0;
    c = int'(m[0]);
    for (int g = 0; g < 8; g++) begin
      s = int'(a[g*4 +: 4]) + int'(b[g*4 +: 4]) + c;
      r[g*4 +: 4] = 4'(s % 16) ^ {3'b000, m[8+g]};
      if (g < 7) c = (s / 16) ^ int'(m[g+1]);
      else r[32] = (s >= 16);
    end
    return r;
  endfunction

  // Behavioural model state
  bit          model_on  = 1'b0;
  bit          m_s1v     = 1'b0;
  bit          m_ov      = 1'b0;
  logic [31:0] m_a       = '0;
  logic [31:0] m_b       = '0;
  logic [32:0] m_res     = '0;
  logic [15:0] m_key     = '0;
  logic [15:0] m_sh      = '0;
  bit          m_kl      = 1'b0;
  bit          m_loading = 1'b0;
  int          m_nb      = 0;
  int          m_acc     = 0;

  // One compare/update per cycle, on the falling edge, inputs stable since posedge+1.
  always @(negedge clk) begin : cmp_proc
    bit out_free;
    bit exp_rdy;
    if (model_on) begin
      out_free = !m_ov || bus_if.out_ready_i;
      exp_rdy  = !m_s1v || out_free;
      chk("in_ready", 64'(bus_if.in_ready_o), 64'(exp_rdy));
      chk("out_valid", 64'(bus_if.out_valid_o), 64'(m_ov));
      chk("key_loaded", 64'(bus_if.key_loaded_o), 64'(m_kl));
      if (m_ov) chk("result", 64'(bus_if.result_o), 64'(m_res));
      if (rst) begin
        m_s1v = 0; m_ov = 0; m_res = '0; m_key = '0; m_sh = '0;
        m_kl = 0; m_loading = 0; m_nb = 0;
      end else begin
        if (out_free) begin
          if (m_s1v) m_res = ref_add(m_a, m_b, m_key);
          m_ov = m_s1v;
        end
        if (exp_rdy) begin
          m_s1v = bus_if.in_valid_i;
          m_a   = bus_if.add1_i;
          m_b   = bus_if.add2_i;
          if (bus_if.in_valid_i) m_acc++;
        end
        if (bus_if.key_start_i) begin
          m_loading = 1; m_nb = 0;
        end else if (m_loading && bus_if.key_shift_i) begin
          m_sh = {m_sh[14:0], bus_if.key_bit_i};
          m_nb++;
          if (m_nb == 16) begin
            m_key = m_sh; m_kl = 1; m_loading = 0;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b);
    bit acc = 1'b0;
    bus_if.add1_i = a;
    bus_if.add2_i = b;
    bus_if.in_valid_i = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = bus_if.in_ready_o;
      tick();
    end
    bus_if.in_valid_i = 1'b0;
    chk("send_accepted", 64'(acc), 64'(1));
  endtask

  task automatic expect_out(input string name, input logic [32:0] exp);
    bit seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (bus_if.out_valid_o) begin
        seen = 1'b1;
        chk(name, 64'(bus_if.result_o), 64'(exp));
      end
      tick();
    end
    chk({name, "_seen"}, 64'(seen), 64'(1));
  endtask

  task automatic key_start();
    bus_if.key_start_i = 1'b1;
    tick();
    bus_if.key_start_i = 1'b0;
  endtask

  task automatic key_bits(input logic [15:0] k, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) begin
      bus_if.key_bit_i   = k[i];
      bus_if.key_shift_i = 1'b1;
      tick();
    end
    bus_if.key_shift_i = 1'b0;
  endtask

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 7))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h0;
      default: return 32'($urandom);
    endcase
  endfunction

  logic [15:0] ref_key = KEY_REF;

  initial begin
    int acc;
    int k;
    int cyc;
    bit use_ref;
    int ridx;
    logic [31:0] t3_a [3];
    logic [31:0] t3_b [3];

    bus_if.add1_i = '0; bus_if.add2_i = '0; bus_if.in_valid_i = 1'b0;
    bus_if.out_ready_i = 1'b0; bus_if.key_start_i = 1'b0;
    bus_if.key_bit_i = 1'b0; bus_if.key_shift_i = 1'b0;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    model_on = 1'b1;

    // Model pins against hand-computed values
    chk("pin_nokey", 64'(ref_add(32'h0, 32'h0, 16'h0)), 64'(33'h0_0110_0110));
    chk("pin_wrap", 64'(ref_add(32'hFFFF_FFFF, 32'h1, KEY_REF)), 64'(33'h1_0000_0000));
    chk("pin_sum", 64'(ref_add(32'h1234_5678, 32'h0FED_CBA8, KEY_REF)), 64'(33'h0_2222_2220));

    // Reset state
    @(negedge clk);
    chk("rst_result", 64'(bus_if.result_o), 64'(0));
    chk("rst_out_valid", 64'(bus_if.out_valid_o), 64'(0));
    chk("rst_key_loaded", 64'(bus_if.key_loaded_o), 64'(0));
    chk("rst_in_ready", 64'(bus_if.in_ready_o), 64'(1));
    tick();

    // 1: no key, 0+0 with full mismatch, two-cycle latency
    bus_if.out_ready_i = 1'b1;
    send(32'h0, 32'h0);
    @(negedge clk);
    chk("t1_not_yet", 64'(bus_if.out_valid_o), 64'(0));
    tick();
    @(negedge clk);
    chk("t1_valid", 64'(bus_if.out_valid_o), 64'(1));
    chk("t1_result", 64'(bus_if.result_o), 64'(33'h0_0110_0110));
    tick();

    // 2: correct key, exact sums
    key_start();
    key_bits(KEY_REF, 15, 0);
    send(32'hFFFF_FFFF, 32'h1);
    expect_out("t2_wrap", 33'h1_0000_0000);
    send(32'h1234_5678, 32'h0FED_CBA8);
    expect_out("t2_sum", 33'h0_2222_2220);
    @(negedge clk);
    chk("t2_key_loaded", 64'(bus_if.key_loaded_o), 64'(1));
    tick();

    // 3: back-to-back with output stalled for 3 cycles
    t3_a[0] = 32'h1111_1111; t3_b[0] = 32'h2222_2222;
    t3_a[1] = 32'h8000_0000; t3_b[1] = 32'h8000_0000;
    t3_a[2] = 32'h0000_0005; t3_b[2] = 32'h0000_0006;
    bus_if.out_ready_i = 1'b0;
    acc = 0; k = 0;
    bus_if.add1_i = t3_a[0]; bus_if.add2_i = t3_b[0]; bus_if.in_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus_if.in_ready_o) begin acc++; k++; end
      tick();
      bus_if.add1_i = t3_a[k]; bus_if.add2_i = t3_b[k];
    end
    @(negedge clk);
    chk("t3_ready_low", 64'(bus_if.in_ready_o), 64'(0));
    chk("t3_accepts", 64'(acc), 64'(2));
    chk("t3_held", 64'(bus_if.result_o), 64'(33'h0_3333_3333));
    tick();
    bus_if.in_valid_i = 1'b0;
    bus_if.out_ready_i = 1'b1;
    expect_out("t3_r0", 33'h0_3333_3333);
    expect_out("t3_r1", 33'h1_0000_0000);
    @(negedge clk);
    chk("t3_drained", 64'(bus_if.out_valid_o), 64'(0));
    tick();

    // 4: restart mid-load; old key stays active until the 16th new bit
    key_start();
    key_bits(16'h1111, 15, 0);
    send(32'h3, 32'h4);
    expect_out("t4_oldkey", ref_add(32'h3, 32'h4, 16'h1111));
    key_start();
    key_bits(16'h5A5A, 15, 9);
    bus_if.key_start_i = 1'b1; bus_if.key_shift_i = 1'b1; bus_if.key_bit_i = 1'b1;
    tick();
    bus_if.key_start_i = 1'b0; bus_if.key_shift_i = 1'b0;
    key_bits(KEY_REF, 15, 1);
    send(32'h3, 32'h4);
    expect_out("t4_15bits", ref_add(32'h3, 32'h4, 16'h1111));
    key_bits(KEY_REF, 0, 0);
    send(32'h3, 32'h4);
    expect_out("t4_newkey", 33'h0_0000_0007);

    // 5: reset mid-load with two ops in flight
    key_start();
    key_bits(KEY_REF, 15, 6);
    bus_if.out_ready_i = 1'b0;
    send(32'h1, 32'h2);
    send(32'h3, 32'h4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_out_valid", 64'(bus_if.out_valid_o), 64'(0));
    chk("t5_key_loaded", 64'(bus_if.key_loaded_o), 64'(0));
    tick();
    bus_if.out_ready_i = 1'b1;
    send(32'h0, 32'h0);
    expect_out("t5_nokey", 33'h0_0110_0110);

    // 6: randomized traffic, keys and occasional resets
    cyc = 0; use_ref = 1'b0; ridx = 15; acc = m_acc;
    while ((m_acc - acc) < 10000 && cyc < 40000) begin
      rst = ($urandom_range(0, 2999) == 0);
      bus_if.in_valid_i  = ($urandom_range(0, 9) < 7);
      bus_if.add1_i      = rand_op();
      bus_if.add2_i      = rand_op();
      bus_if.out_ready_i = ($urandom_range(0, 9) < 7);
      bus_if.key_start_i = ($urandom_range(0, 59) == 0);
      if (bus_if.key_start_i) begin
        use_ref = 1'($urandom_range(0, 1));
        ridx = 15;
      end
      bus_if.key_shift_i = 1'($urandom_range(0, 1));
      bus_if.key_bit_i   = use_ref ? ref_key[ridx] : 1'($urandom_range(0, 1));
      if (bus_if.key_shift_i && !bus_if.key_start_i && ridx > 0) ridx--;
      tick();
      cyc++;
    end
    rst = 1'b0;
    bus_if.in_valid_i = 1'b0; bus_if.key_start_i = 1'b0; bus_if.key_shift_i = 1'b0;
    bus_if.out_ready_i = 1'b1;
    repeat (5) tick();
    chk("t6_ops_done", 64'((m_acc - acc) >= 10000), 64'(1));

    model_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
